ula_result_buffer: RTL and testbench

Registered output stage placed directly downstream of the ULA datapath (adder, multiplier, `ula_divisor`). It captures each 16-bit result together with its sign/zero flags through a valid/ready handshake and holds it in a small FIFO until the consumer (register file / display logic) accepts it. A division whose divisor is zero is detected and replaced by a defined error record. A saturating count of delivered results is kept for debug.

---
 rtl/ula_result_buffer_if.sv | 64 ++++++
 rtl/ula_result_buffer.sv | 131 +++++++++++++
 tb/tb_ula_result_buffer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ula_result_buffer_if.sv
// Handshake bundle between the ULA datapath, the result buffer and its consumer.
// The buffer connects through the slave modport; the producer/consumer side uses master.
interface ula_result_buffer_if #(
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    // Upstream (ULA) side
    logic            in_valid;
    logic            in_ready;
    logic [15:0]     in_result;
    logic            in_sign_flag;
    logic            in_zero_flag;
    logic [2:0]      in_opcode;
    logic [7:0]      in_b;

    // Downstream (consumer) side
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     out_result;
    logic            out_sign_flag;
    logic            out_zero_flag;
    logic            out_div_error;

    // Status
    logic [CntW-1:0] count;
    logic [15:0]     delivered;

    modport master (
        output in_valid,
        output in_result,
        output in_sign_flag,
        output in_zero_flag,
        output in_opcode,
        output in_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result,
        input  out_sign_flag,
        input  out_zero_flag,
        input  out_div_error,
        input  count,
        input  delivered
    );

    modport slave (
        input  in_valid,
        input  in_result,
        input  in_sign_flag,
        input  in_zero_flag,
        input  in_opcode,
        input  in_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result,
        output out_sign_flag,
        output out_zero_flag,
        output out_div_error,
        output count,
        output delivered
    );
endinterface

// File: rtl/ula_result_buffer.sv
// Small FIFO that registers ULA results and flags, replaces divide-by-zero results with an
// error record and keeps a saturating count of results handed to the consumer.
module ula_result_buffer #(
    parameter int unsigned DEPTH      = 2,
    parameter logic [2:0]  DIV_OPCODE = 3'b011
) (
    input logic                clk,
    input logic                reset,
    ula_result_buffer_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
    localparam logic [15:0] DeliveredMax = 16'hFFFF;

    // Slot storage
    logic [15:0]      result_q [DEPTH];
    logic [DEPTH-1:0] sign_q;
    logic [DEPTH-1:0] zero_q;
    logic [DEPTH-1:0] err_q;

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [15:0]      delivered_q, delivered_d;

    logic             in_ready;
    logic             out_valid;
    logic             push;
    logic             pop;
    logic             div_by_zero;

    logic [15:0]      wr_result;
    logic             wr_sign;
    logic             wr_zero;
    logic             wr_err;

    // Ready comes from registered occupancy only, so out_ready never reaches in_ready.
    assign in_ready  = (count_q < DepthCnt);
    assign out_valid = (count_q != '0);
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    assign div_by_zero = (bus.in_opcode == DIV_OPCODE) && (bus.in_b == 8'h00);

    always_comb begin
        wr_result = bus.in_result;
        wr_sign   = bus.in_sign_flag;
        wr_zero   = bus.in_zero_flag;
        wr_err    = 1'b0;
        if (div_by_zero) begin
            wr_result = 16'h0000;
            wr_sign   = 1'b0;
            wr_zero   = 1'b1;
            wr_err    = 1'b1;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural PtrW-bit overflow.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        delivered_d = delivered_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (delivered_q != DeliveredMax) begin
                delivered_d = delivered_q + 16'd1;
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            delivered_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            delivered_q <= delivered_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                result_q[i] <= 16'h0000;
            end
            sign_q <= '0;
            zero_q <= '0;
            err_q  <= '0;
        end else if (push) begin
            result_q[wr_ptr_q] <= wr_result;
            sign_q[wr_ptr_q]   <= wr_sign;
            zero_q[wr_ptr_q]   <= wr_zero;
            err_q[wr_ptr_q]    <= wr_err;
        end
    end

    // Head is masked while empty so retired slots never leak onto the outputs.
    always_comb begin
        bus.out_result    = 16'h0000;
        bus.out_sign_flag = 1'b0;
        bus.out_zero_flag = 1'b0;
        bus.out_div_error = 1'b0;
        if (out_valid) begin
            bus.out_result    = result_q[rd_ptr_q];
            bus.out_sign_flag = sign_q[rd_ptr_q];
            bus.out_zero_flag = zero_q[rd_ptr_q];
            bus.out_div_error = err_q[rd_ptr_q];
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.count     = count_q;
    assign bus.delivered = delivered_q;
endmodule

// File: tb/tb_ula_result_buffer.sv
// Directed bench for ula_result_buffer: ordering, backpressure, divide-by-zero records,
// wrap-around streaming, asynchronous reset and saturation of the delivered counter.
module tb_ula_result_buffer;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    ula_result_buffer_if #(.DEPTH(2)) bus ();

    ula_result_buffer #(
        .DEPTH     (2),
        .DIV_OPCODE(3'b011)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic valid, input logic [15:0] res, input logic sign,
                            input logic zero, input logic [2:0] op, input logic [7:0] b);
        bus.in_valid     = valid;
        bus.in_result    = res;
        bus.in_sign_flag = sign;
        bus.in_zero_flag = zero;
        bus.in_opcode    = op;
        bus.in_b         = b;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        drive_in(1'b0, 16'h0000, 1'b0, 1'b0, 3'b000, 8'h00);
        bus.out_ready = 1'b0;
        #3;
        step();
        reset = 1'b0;

        // Reset state
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_count", 32'(bus.count), 32'h0);
        check("rst_delivered", 32'(bus.delivered), 32'h0);
        check("rst_out_result", 32'(bus.out_result), 32'h0);
        check("rst_flags", 32'({bus.out_sign_flag, bus.out_zero_flag, bus.out_div_error}), 32'h0);

        // Single push, then single pop
        drive_in(1'b1, 16'h0005, 1'b0, 1'b0, 3'b000, 8'h00);
        step();
        drive_in(1'b0, 16'h0000, 1'b0, 1'b0, 3'b000, 8'h00);
        check("single_valid", 32'(bus.out_valid), 32'h1);
        check("single_result", 32'(bus.out_result), 32'h0005);
        check("single_count", 32'(bus.count), 32'h1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("single_pop_count", 32'(bus.count), 32'h0);
        check("single_pop_deliv", 32'(bus.delivered), 32'h1);
        check("single_pop_valid", 32'(bus.out_valid), 32'h0);

        // Backpressure at full, third result held upstream
        drive_in(1'b1, 16'h00A1, 1'b0, 1'b0, 3'b000, 8'h00);
        step();
        drive_in(1'b1, 16'h00A2, 1'b1, 1'b0, 3'b001, 8'h00);
        step();
        check("full_in_ready", 32'(bus.in_ready), 32'h0);
        check("full_count", 32'(bus.count), 32'h2);
        drive_in(1'b1, 16'h00A3, 1'b0, 1'b1, 3'b010, 8'h00);
        step();
        check("full_hold_count", 32'(bus.count), 32'h2);
        check("full_head", 32'(bus.out_result), 32'h00A1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("refill_in_ready", 32'(bus.in_ready), 32'h1);
        check("refill_count", 32'(bus.count), 32'h1);
        check("refill_head", 32'(bus.out_result), 32'h00A2);
        check("refill_head_sign", 32'(bus.out_sign_flag), 32'h1);
        step();
        drive_in(1'b0, 16'h0000, 1'b0, 1'b0, 3'b000, 8'h00);
        check("third_accepted", 32'(bus.count), 32'h2);
        bus.out_ready = 1'b1;
        step();
        check("order_third", 32'(bus.out_result), 32'h00A3);
        check("order_third_zero", 32'(bus.out_zero_flag), 32'h1);
        step();
        bus.out_ready = 1'b0;
        check("drain_count", 32'(bus.count), 32'h0);
        check("drain_deliv", 32'(bus.delivered), 32'h4);

        // Divide-by-zero record, then verbatim division and non-division with b=0
        drive_in(1'b1, 16'h1234, 1'b1, 1'b0, 3'b011, 8'h00);
        step();
        check("dz_result", 32'(bus.out_result), 32'h0000);
        check("dz_flags", 32'({bus.out_sign_flag, bus.out_zero_flag, bus.out_div_error}),
              32'b011);
        drive_in(1'b1, 16'hFFFE, 1'b1, 1'b0, 3'b011, 8'hFD);
        bus.out_ready = 1'b1;
        step();
        check("div_result", 32'(bus.out_result), 32'hFFFE);
        check("div_flags", 32'({bus.out_sign_flag, bus.out_zero_flag, bus.out_div_error}),
              32'b100);
        check("div_count", 32'(bus.count), 32'h1);
        drive_in(1'b1, 16'h0077, 1'b0, 1'b0, 3'b010, 8'h00);
        step();
        check("nondiv_b0_result", 32'(bus.out_result), 32'h0077);
        check("nondiv_b0_err", 32'(bus.out_div_error), 32'h0);
        drive_in(1'b0, 16'h0000, 1'b0, 1'b0, 3'b000, 8'h00);
        step();
        bus.out_ready = 1'b0;
        check("dz_drain_count", 32'(bus.count), 32'h0);
        check("dz_drain_deliv", 32'(bus.delivered), 32'h7);

        // Streaming push+pop with pointer wrap
        drive_in(1'b1, 16'd1, 1'b0, 1'b0, 3'b000, 8'h00);
        step();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            check("stream_head", 32'(bus.out_result), 32'(i));
            check("stream_count", 32'(bus.count), 32'h1);
            drive_in(i < 10, 16'(i + 1), 1'b0, 1'b0, 3'b000, 8'h00);
            step();
        end
        bus.out_ready = 1'b0;
        check("stream_end_count", 32'(bus.count), 32'h0);
        check("stream_end_deliv", 32'(bus.delivered), 32'd17);

        // Asynchronous reset while full
        drive_in(1'b1, 16'h0B01, 1'b0, 1'b0, 3'b000, 8'h00);
        step();
        drive_in(1'b1, 16'h0B02, 1'b0, 1'b0, 3'b000, 8'h00);
        step();
        drive_in(1'b0, 16'h0000, 1'b0, 1'b0, 3'b000, 8'h00);
        check("pre_areset_count", 32'(bus.count), 32'h2);
        #2;
        reset = 1'b1;
        #1;
        check("areset_valid", 32'(bus.out_valid), 32'h0);
        check("areset_count", 32'(bus.count), 32'h0);
        check("areset_deliv", 32'(bus.delivered), 32'h0);
        check("areset_in_ready", 32'(bus.in_ready), 32'h1);
        check("areset_result", 32'(bus.out_result), 32'h0);
        step();
        reset = 1'b0;
        step();
        check("post_areset_count", 32'(bus.count), 32'h0);

        // Saturation of delivered: one push-only edge, then one pop per edge
        drive_in(1'b1, 16'h5A5A, 1'b0, 1'b0, 3'b000, 8'h00);
        bus.out_ready = 1'b1;
        repeat (65535) step();
        check("sat_pre_deliv", 32'(bus.delivered), 32'hFFFE);
        step();
        check("sat_deliv", 32'(bus.delivered), 32'hFFFF);
        check("sat_count", 32'(bus.count), 32'h1);
        drive_in(1'b0, 16'h0000, 1'b0, 1'b0, 3'b000, 8'h00);
        step();
        bus.out_ready = 1'b0;
        check("sat_hold_deliv", 32'(bus.delivered), 32'hFFFF);
        check("sat_hold_count", 32'(bus.count), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
